seg_shift_tx: RTL and testbench
===============================

# seg_shift_tx

Serial transmitter for the board's 7-segment display path. It accepts one 64-bit frame of segment bits, which is eight bytes of segment patterns produced by the segment mapping logic. It shifts the frame MSB-first into the external 74HC595-style shift-register chain, then pulses the latch so the chain's outputs update together. It sits between the display-data mux and the board pins and is the only block that drives the serial display lines.

## Interface
Parameters:
- DIV, default 2: half-period of `sclk`, in `clk` cycles; legal range 1–255.
- FRAME_W, default 64: bits per frame; fixed at 64 for this board, but kept parameterised for the LED chain.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst_n  input  1  reset, asynchronous and active-low; it clears every register immediately.
- start  input  1  request to send one frame; sampled only in IDLE.
- data  input  FRAME_W  frame to send; captured on the edge that accepts `start`.
- sclk  output  1  serial clock to the chain; the chain samples `sdata` on the rising edge of `sclk`.
- sdata  output  1  serial data, MSB first.
- slatch  output  1  storage-register latch; active high.
- busy  output  1  a frame is in progress.
- done  output  1  one-cycle pulse when a frame completes.

## Operation
- FSM states:
  - IDLE: waiting for a request.
  - SHIFT: sending the frame bit by bit.
  - LATCH: pulsing `slatch`.
  - DONE: one cycle, then back to IDLE.
- IDLE:
  - If `start`=1, load `data` into the shift register, clear the bit and divider counters, and go to SHIFT.
  - `start`=0 keeps the FSM in IDLE.
- SHIFT:
  - Each bit lasts 2·DIV cycles.
  - `sdata` = shift register bit [FRAME_W-1] for the whole bit period.
  - `sclk`=0 for the first DIV cycles of the bit and 1 for the last DIV cycles.
  - At the end of the high phase, shift the register left by one (fill with 0) and increment the bit counter.
  - After bit FRAME_W-1, go to LATCH.
- LATCH: `sclk`=0, `sdata`=0 and `slatch`=1 for DIV cycles, then go to DONE.
- DONE: `done`=1 for one cycle, then go to IDLE.
- `busy`=1 in SHIFT and LATCH only.
- `start` in any state other than IDLE is ignored; it is not queued.
- A new `start` may be accepted in the cycle after DONE.
- Changes on `data` while busy have no effect on the frame in progress.
- Divider counter: width of $clog2(DIV+1). It wraps to 0 at DIV-1 and is shared by SHIFT and LATCH.
- Bit counter: width of $clog2(FRAME_W+1). It does not wrap within a frame.
- Reset mid-frame: all outputs go to their reset values at once, the FSM returns to IDLE, and the partial frame is discarded.
  - No `slatch` pulse is produced, so the chain keeps its previous latched contents.

## Timing
- Reset values: `sclk`=0, `sdata`=0, `slatch`=0, `busy`=0, `done`=0, FSM in IDLE.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- Let the accepting edge be E0. Then:
  - `busy` rises after E0 and stays high for exactly FRAME_W·2·DIV + DIV cycles.
  - `done` is high in the single cycle right after `busy` falls.
- With the defaults, `busy` is high for 258 cycles and `done` is high in cycle 259 after E0.
- `sdata` changes only while `sclk`=0, which gives DIV cycles of setup and DIV cycles of hold around each rising edge of `sclk`.
- Exactly FRAME_W rising edges of `sclk` occur per frame, and none occur in LATCH, DONE or IDLE.
- With DIV=1, `sclk` toggles every cycle and the `slatch` pulse lasts 1 cycle.

## Structure
- Shared package `seg_pkg` holds:
  - SEG_FRAME_W = 64.
  - The state encoding constants ST_IDLE, ST_SHIFT, ST_LATCH, ST_DONE.
- The FSM, shift register and bit counter stay in this module.
- The divider is a natural sub-module, `seg_clk_div`. Its ports are `clk`, `rst_n`, `en` and `clr`, and it outputs `half_tick` (high on the last cycle of each DIV-cycle half period).
  - The LED chain transmitter reuses `seg_clk_div`.

## Test plan
- Reset during SHIFT at bit 10 -> the next cycle has all outputs at 0 and the FSM in IDLE, and `slatch` never pulses. A following `start` with 64'h0123_4567_89AB_CDEF sends the full frame correctly.
- DIV=2, `data`=64'h8000_0000_0000_0001 -> 64 rising edges of `sclk`. `sdata`=1 at edge 1 and edge 64 and 0 at all others. `slatch` is high for 2 cycles. `done` is high in cycle 259 after E0.
- DIV=2, `data`=64'hFFFF_FFFF_FFFF_FFFF; capture `sdata` in a model 595 chain -> the chain holds all ones after `slatch`. Repeat with 64'h0 and the chain holds all zeros.
- `start` held high continuously, with `data` changing every cycle -> the frames are back-to-back. Each frame equals the `data` value at its accepting edge, and there is a gap of exactly 1 DONE cycle plus 1 IDLE cycle between frames.
- DIV=1, `data`=64'hA5A5_A5A5_A5A5_A5A5 -> `sclk` period is 2 cycles. The bit sequence reads 1010_0101 repeated. `busy` is high for 129 cycles.

Source files
------------

// File: rtl/seg_pkg.sv
// Shared definitions for the serial display transmitters.
//   SEG_FRAME_W : bits per 7-segment frame (eight segment bytes)
//   seg_state_e : transmitter FSM states
package seg_pkg;

  localparam int unsigned SEG_FRAME_W = 64;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_LATCH = 2'd2,
    ST_DONE  = 2'd3
  } seg_state_e;

endpackage

// File: rtl/seg_clk_div.sv
// Half-period divider for serial clock generation.
//   clk, rst_n : system clock, async active-low reset
//   en         : count while high
//   clr        : synchronous clear of the counter (wins over en)
//   half_tick  : high on the last cycle of each DIV-cycle half period
module seg_clk_div #(
  parameter int unsigned DIV = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic half_tick
);

  localparam int unsigned CW = $clog2(DIV + 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          last;

  assign last      = (cnt_q == CW'(DIV - 1));
  assign half_tick = en && !clr && last;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = last ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/seg_shift_tx.sv
// Serial transmitter for the 7-segment 74HC595-style chain.
// Shifts one FRAME_W-bit frame MSB first, then pulses the latch.
//   clk, rst_n : system clock, async active-low reset
//   start      : send request, sampled in IDLE only
//   data       : frame, captured on the accepting edge
//   sclk       : serial clock (chain samples on rising edge)
//   sdata      : serial data, MSB first
//   slatch     : storage latch, active high, DIV cycles
//   busy       : high in SHIFT and LATCH
//   done       : one-cycle pulse after the frame completes
module seg_shift_tx
  import seg_pkg::*;
#(
  parameter int unsigned DIV     = 2,
  parameter int unsigned FRAME_W = SEG_FRAME_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [FRAME_W-1:0] data,
  output logic               sclk,
  output logic               sdata,
  output logic               slatch,
  output logic               busy,
  output logic               done
);

  localparam int unsigned BW = $clog2(FRAME_W + 1);

  seg_state_e         state_q, state_d;
  logic [FRAME_W-1:0] sreg_q, sreg_d;
  logic [BW-1:0]      bit_q, bit_d;
  logic               phase_q, phase_d;   // 0: sclk low half, 1: sclk high half

  logic sclk_q, sclk_d;
  logic sdata_q, sdata_d;
  logic slatch_q, slatch_d;
  logic busy_q, busy_d;
  logic done_q, done_d;

  logic div_en, div_clr, half_tick;

  seg_clk_div #(.DIV(DIV)) u_div (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (div_en),
    .clr       (div_clr),
    .half_tick (half_tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      sreg_q   <= '0;
      bit_q    <= '0;
      phase_q  <= 1'b0;
      sclk_q   <= 1'b0;
      sdata_q  <= 1'b0;
      slatch_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      sreg_q   <= sreg_d;
      bit_q    <= bit_d;
      phase_q  <= phase_d;
      sclk_q   <= sclk_d;
      sdata_q  <= sdata_d;
      slatch_q <= slatch_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sreg_d  = sreg_q;
    bit_d   = bit_q;
    phase_d = phase_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_SHIFT;
          sreg_d  = data;
          bit_d   = '0;
          phase_d = 1'b0;
        end
      end
      ST_SHIFT: begin
        if (half_tick) begin
          if (!phase_q) begin
            phase_d = 1'b1;
          end else begin
            phase_d = 1'b0;
            sreg_d  = {sreg_q[FRAME_W-2:0], 1'b0};
            bit_d   = bit_q + 1'b1;
            if (bit_q == BW'(FRAME_W - 1)) state_d = ST_LATCH;
          end
        end
      end
      ST_LATCH: begin
        if (half_tick) state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs are decoded from next-state values and registered, so each
  // output register lines up with the state register it describes.
  always_comb begin
    div_en   = (state_q == ST_SHIFT) || (state_q == ST_LATCH);
    div_clr  = (state_q == ST_IDLE);
    sclk_d   = (state_d == ST_SHIFT) && phase_d;
    sdata_d  = (state_d == ST_SHIFT) && sreg_d[FRAME_W-1];
    slatch_d = (state_d == ST_LATCH);
    busy_d   = (state_d == ST_SHIFT) || (state_d == ST_LATCH);
    done_d   = (state_d == ST_DONE);
  end

  assign sclk   = sclk_q;
  assign sdata  = sdata_q;
  assign slatch = slatch_q;
  assign busy   = busy_q;
  assign done   = done_q;

endmodule

// File: tb/tb_seg_shift_tx.sv
module tb_seg_shift_tx;
  import seg_pkg::*;

  localparam int DIVS [2] = '{2, 1};

  logic        clk;
  logic        rst_n;
  logic [1:0]  start_v;
  logic [63:0] data_v [2];
  wire  [1:0]  sclk_v, sdata_v, slatch_v, busy_v, done_v;

  int n_checks;
  int n_errors;

  logic [63:0] q0 [$];
  logic [63:0] q1 [$];

  seg_shift_tx #(.DIV(2), .FRAME_W(64)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .start(start_v[0]), .data(data_v[0]),
    .sclk(sclk_v[0]), .sdata(sdata_v[0]), .slatch(slatch_v[0]),
    .busy(busy_v[0]), .done(done_v[0])
  );

  seg_shift_tx #(.DIV(1), .FRAME_W(64)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start_v[1]), .data(data_v[1]),
    .sclk(sclk_v[1]), .sdata(sdata_v[1]), .slatch(slatch_v[1]),
    .busy(busy_v[1]), .done(done_v[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s got=%h want=%h t=%0t", tag, got, want, $time);
    end
  endtask

  task automatic push_exp(input int inst, input logic [63:0] d);
    if (inst == 0) q0.push_back(d);
    else           q1.push_back(d);
  endtask

  // Model 595 chain per instance, fed by sclk/sdata, compared at slatch.
  logic [63:0] chain   [2];
  int          edges   [2];
  int          lat_len [2];
  logic        p_sclk  [2];
  logic        p_sdata [2];
  logic        p_slat  [2];

  initial begin
    for (int i = 0; i < 2; i++) begin
      chain[i] = '0; edges[i] = 0; lat_len[i] = 0;
      p_sclk[i] = 1'b0; p_sdata[i] = 1'b0; p_slat[i] = 1'b0;
    end
  end

  always @(negedge clk) begin
    logic [63:0] want;
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) begin
        edges[i]   = 0;
        lat_len[i] = 0;
      end else begin
        if (sclk_v[i] && !p_sclk[i]) begin
          check("sclk_rise_busy", {63'd0, busy_v[i]}, 64'd1);
          edges[i]++;
          chain[i] = {chain[i][62:0], sdata_v[i]};
        end
        if (sclk_v[i] && p_sclk[i])
          check("sdata_hold", {63'd0, sdata_v[i]}, {63'd0, p_sdata[i]});
        if (slatch_v[i]) lat_len[i]++;
        if (slatch_v[i] && !p_slat[i]) begin
          check("sclk_edges", 64'(edges[i]), 64'd64);
          edges[i] = 0;
          if ((i == 0 && q0.size() == 0) || (i == 1 && q1.size() == 0)) begin
            check("unexpected_latch", 64'd1, 64'd0);
          end else begin
            if (i == 0) want = q0.pop_front();
            else        want = q1.pop_front();
            check("frame", chain[i], want);
          end
        end
        if (!slatch_v[i] && p_slat[i]) begin
          check("latch_len", 64'(lat_len[i]), 64'(DIVS[i]));
          lat_len[i] = 0;
        end
      end
      p_sclk[i]  = sclk_v[i];
      p_sdata[i] = sdata_v[i];
      p_slat[i]  = slatch_v[i];
    end
  end

  // One frame with per-cycle timing checks relative to the accepting edge.
  task automatic send(input int inst, input logic [63:0] d);
    int div;
    int len;
    logic exp_sclk;
    div = DIVS[inst];
    len = 64 * 2 * div + div;
    @(negedge clk);
    start_v[inst] = 1'b1;
    data_v[inst]  = d;
    @(posedge clk);
    push_exp(inst, d);
    #1;
    start_v[inst] = 1'b0;
    data_v[inst]  = ~d;
    for (int k = 1; k <= len + 2; k++) begin
      @(negedge clk);
      exp_sclk = (k <= 128 * div) ? 1'(((k - 1) / div) % 2) : 1'b0;
      check("busy",   {63'd0, busy_v[inst]},   {63'd0, 1'(k <= len)});
      check("done",   {63'd0, done_v[inst]},   {63'd0, 1'(k == len + 1)});
      check("sclk",   {63'd0, sclk_v[inst]},   {63'd0, exp_sclk});
      check("slatch", {63'd0, slatch_v[inst]}, {63'd0, 1'(k > 128 * div && k <= len)});
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    for (int i = 0; i < 2; i++) begin
      check({tag, "_sclk"},   {63'd0, sclk_v[i]},   64'd0);
      check({tag, "_sdata"},  {63'd0, sdata_v[i]},  64'd0);
      check({tag, "_slatch"}, {63'd0, slatch_v[i]}, 64'd0);
      check({tag, "_busy"},   {63'd0, busy_v[i]},   64'd0);
      check({tag, "_done"},   {63'd0, done_v[i]},   64'd0);
    end
    check({tag, "_state0"}, 64'(u_dut0.state_q), 64'(ST_IDLE));
    check({tag, "_state1"}, 64'(u_dut1.state_q), 64'(ST_IDLE));
  endtask

  initial begin
    int period;
    n_checks  = 0;
    n_errors  = 0;
    rst_n     = 1'b0;
    start_v   = '0;
    data_v[0] = '0;
    data_v[1] = '0;
    repeat (3) @(negedge clk);
    check_outputs_zero("reset");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    send(0, 64'h8000_0000_0000_0001);
    send(0, 64'hFFFF_FFFF_FFFF_FFFF);
    send(0, 64'h0000_0000_0000_0000);

    // Abort during bit 10 of a DIV=2 frame.
    @(negedge clk);
    start_v[0] = 1'b1;
    data_v[0]  = 64'hDEAD_BEEF_CAFE_F00D;
    @(posedge clk);
    #1;
    start_v[0] = 1'b0;
    repeat (42) @(negedge clk);
    check("pre_reset_busy", {63'd0, busy_v[0]}, 64'd1);
    #1;
    rst_n = 1'b0;
    #1;
    check_outputs_zero("abort");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    send(0, 64'h0123_4567_89AB_CDEF);

    send(1, 64'hA5A5_A5A5_A5A5_A5A5);

    // start held high on DIV=1, data changing every cycle.
    period = 64 * 2 + 1 + 2;
    @(negedge clk);
    start_v[1] = 1'b1;
    data_v[1]  = {$urandom, $urandom};
    for (int c = 0; c < 3 * period; c++) begin
      @(posedge clk);
      if (c % period == 0) q1.push_back(data_v[1]);
      @(negedge clk);
      check("b2b_busy", {63'd0, busy_v[1]}, {63'd0, 1'((c % period) + 1 <= period - 2)});
      check("b2b_done", {63'd0, done_v[1]}, {63'd0, 1'((c % period) + 1 == period - 1)});
      data_v[1] = {$urandom, $urandom};
      if (c == 3 * period - 1) start_v[1] = 1'b0;
    end

    repeat (5) @(negedge clk);
    check("queue_drained", 64'(q0.size() + q1.size()), 64'd0);
    check("idle_end_busy", {62'd0, busy_v}, 64'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
